datapath: RTL and testbench
===========================

# datapath

Multicycle MIPS datapath: the stage directly downstream of the multicycle `controller`, consuming its control bundle and returning `op`, `funct` and `zero` to it. It holds the architectural and non-architectural state of the multicycle core: PC, IR, MDR, A, B, ALUOut and the 32x32 register file. It also contains the ALU and all datapath muxes. A single unified memory sits outside the block on `adr`/`writedata`/`readdata`.

## Interface
- `WIDTH`, 32: datapath width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `pcen` in 1: PC write enable.
- `irwrite` in 1: IR write enable.
- `regwrite` in 1: register file write enable.
- `iord` in 1: memory address select; 0 = PC, 1 = ALUOut.
- `memtoreg` in 1: register write-data select; 0 = ALUOut, 1 = MDR.
- `regdst` in 1: destination register select; 0 = `rt` (IR[20:16]), 1 = `rd` (IR[15:11]).
- `alusrca` in 1: ALU A select; 0 = PC, 1 = A.
- `alusrcb` in 2: ALU B select; 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` in 2: next-PC select; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol` in 3: ALU operation; 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `readdata` in 32: memory read data.
- `adr` out 32: memory address.
- `writedata` out 32: memory write data (register B).
- `op` out 6: IR[31:26].
- `funct` out 6: IR[5:0].
- `zero` out 1: high when ALUResult == 0.

## Operation
- SignImm is IR[15:0] sign-extended to 32 bits.
- Register file: two combinational read ports (`rs` = IR[25:21], `rt` = IR[20:16]) and one write port.
  - Writes on the rising edge when `regwrite`=1.
  - Writes to $0 are discarded; $0 always reads 0.
- Registers loaded every cycle, unconditionally: A <= RD1, B <= RD2, MDR <= `readdata`, ALUOut <= ALUResult.
- IR <= `readdata` when `irwrite`=1.
- PC <= PCNext when `pcen`=1.
- ALU arithmetic:
  - add/sub are 32-bit modulo with no overflow flag.
  - slt is a signed compare and yields 32'h1 or 32'h0.
  - Undefined `alucontrol` codes yield 0.
- `adr` = `iord` ? ALUOut : PC (combinational).
- `writedata` = B.
- `op`/`funct` come from IR, not from `readdata`.

## Timing
- Reset (synchronous, `reset`=1 at a rising edge): PC, IR, MDR, A, B, ALUOut and all 32 registers clear to 0.
  - Immediately after reset: `adr`=0 (with `iord`=0), `writedata`=0, `op`=0, `funct`=0.
  - `zero` follows the combinational ALU result.
  - Reset applied mid-instruction discards all in-flight state on that edge.
- Fetch, in one cycle:
  - IR captures `readdata` at the edge.
  - PC <= PC+4 when `alusrca`=0, `alusrcb`=01, `alucontrol`=010, `pcsrc`=00, `pcen`=1.
  - `op`/`funct` are valid from the following cycle.
- Register read to ALU operand: one cycle, through A/B.
- ALU to ALUOut: one cycle.
- Memory read to register file: MDR adds one cycle, giving a load writeback 2 cycles after the address cycle.
- Same-cycle register write and read of the same register: the read returns the old value; the new value is visible the next cycle.
- Simultaneous `irwrite` and `pcen`: IR is loaded from the old PC's `readdata`.

## Configuration
- `DATAPATH_JUMP_EN` defined: `pcsrc`=10 selects {PC[31:28], IR[25:0], 2'b00}.
- `DATAPATH_JUMP_EN` undefined: `pcsrc`=10 behaves as 00 (ALUResult); `pcsrc`=11 behaves as 00 in both builds.

## Test plan
- Reset: hold `reset` 2 cycles with `readdata`=32'hFFFFFFFF → `adr`=0, `op`=0, `funct`=0, `writedata`=0. After release, reading any register returns 0.
- addi $2,$0,5 (32'h20020005):
  - Fetch cycle: `op`=6'h08 next cycle, PC=4.
  - Execute: `alusrca`=1, `alusrcb`=10, add.
  - Writeback: `regdst`=0, `memtoreg`=0, `regwrite`=1 → $2=5.
- R-type or $4,$7,$2 (32'h00e22025), with $7=3 and $2=5 preloaded via addi → $4=7, `funct`=6'h25.
- sw $7,68($3) (32'hac670044), with $3=12 and $7=3 → during the memory cycle (`iord`=1) `adr`=80 and `writedata`=3. Then lw $2,80($0) (32'h8c020050) with `readdata`=3 at `adr`=80 → $2=3 after `memtoreg`=1 writeback.
- beq, rs=rt=5, imm=2, PC=8 after fetch:
  - Decode computes ALUOut=16.
  - Sub gives `zero`=1; `pcsrc`=01 with `pcen`=1 → PC=16.
  - Repeat with unequal registers → `zero`=0 and PC unchanged.
- j 0x0000010 (32'h08000010), `pcsrc`=10, `pcen`=1:
  - With `DATAPATH_JUMP_EN`: PC=0x40.
  - Without it: PC=ALUResult.
  - Also: `regwrite`=1 to $0 with ALUOut=9 → $0 still reads 0.

Source files
------------

// File: rtl/datapath_if.sv
// Bus between the multicycle controller/memory and the datapath: control bundle in,
// op/funct/zero back, plus the unified memory port (adr/writedata/readdata).
interface datapath_if #(
    parameter int WIDTH = 32
);
    logic             pcen;
    logic             irwrite;
    logic             regwrite;
    logic             iord;
    logic             memtoreg;
    logic             regdst;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] readdata;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;

    modport master (
        output pcen, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
               alusrcb, pcsrc, alucontrol, readdata,
        input  adr, writedata, op, funct, zero
    );

    modport slave (
        input  pcen, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
               alusrcb, pcsrc, alucontrol, readdata,
        output adr, writedata, op, funct, zero
    );
endinterface

// File: rtl/datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, 32x32 register file, ALU and muxes.
// Define DATAPATH_JUMP_EN to make pcsrc=10 select the jump target {PC[31:28], IR[25:0], 2'b00}.
module datapath #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    datapath_if.slave bus
);
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    logic [WIDTH-1:0] pc, instr, data, a, b, aluout;
    logic [WIDTH-1:0] rf [32];

    logic [4:0]       rs, rt, rd, wa;
    logic [WIDTH-1:0] rd1, rd2, wd, signimm;
    logic [WIDTH-1:0] srca, srcb, aluresult, pcnext;

    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign signimm = {{(WIDTH-16){instr[15]}}, instr[15:0]};

    assign wa = bus.regdst   ? rd   : rt;
    assign wd = bus.memtoreg ? data : aluout;

    // $0 is hardwired: the read port ignores storage for index 0.
    assign rd1 = (rs == 5'd0) ? '0 : rf[rs];
    assign rd2 = (rt == 5'd0) ? '0 : rf[rt];

    // NOTE: the register file has an architectural reset, so it is built from flops
    // rather than an inferred RAM; writes to $0 are dropped at the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.regwrite && (wa != 5'd0)) begin
            rf[wa] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            instr  <= '0;
            data   <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values,
            // which is what lets IR load from the old PC while PC advances on the same edge.
            if (bus.pcen)    pc    <= pcnext;
            if (bus.irwrite) instr <= bus.readdata;
            data   <= bus.readdata;
            a      <= rd1;
            b      <= rd2;
            aluout <= aluresult;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        srca = bus.alusrca ? a : pc;
        srcb = b;
        case (bus.alusrcb)
            2'b01:   srcb = WIDTH'(4);
            2'b10:   srcb = signimm;
            2'b11:   srcb = {signimm[WIDTH-3:0], 2'b00};
            default: srcb = b;
        endcase
    end

    always_comb begin
        aluresult = '0;
        case (bus.alucontrol)
            ALU_ADD: aluresult = srca + srcb;
            ALU_SUB: aluresult = srca - srcb;
            ALU_AND: aluresult = srca & srcb;
            ALU_OR:  aluresult = srca | srcb;
            ALU_SLT: aluresult = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: aluresult = '0;
        endcase
    end

    always_comb begin
        pcnext = aluresult;
        case (bus.pcsrc)
            2'b01:   pcnext = aluout;
`ifdef DATAPATH_JUMP_EN
            2'b10:   pcnext = {pc[WIDTH-1:WIDTH-4], instr[25:0], 2'b00};
`endif
            default: pcnext = aluresult;
        endcase
    end

    assign bus.adr       = bus.iord ? aluout : pc;
    assign bus.writedata = b;
    assign bus.op        = instr[31:26];
    assign bus.funct     = instr[5:0];
    assign bus.zero      = (aluresult == '0);
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: acts as the multicycle controller and memory,
// checks DUT outputs against an instruction-level MIPS model through a scoreboard.
module tb_datapath;
    typedef enum int {SEL_ADR, SEL_WD, SEL_OP, SEL_FUNCT, SEL_ZERO} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    localparam logic [2:0] AC_ADD = 3'b010;
    localparam logic [2:0] AC_SUB = 3'b110;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [$];

    // Instruction-level model state
    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [logic [31:0]];

    datapath_if bus ();

    datapath #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: drains this cycle's expectations away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_ADR:   act = bus.adr;
                SEL_WD:    act = bus.writedata;
                SEL_OP:    act = {26'b0, bus.op};
                SEL_FUNCT: act = {26'b0, bus.funct};
                default:   act = {31'b0, bus.zero};
            endcase
            check(e.name, act, e.val);
        end
    end

    task automatic expect_out(input string name, input sel_e sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic idle_ctrl();
        bus.pcen       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regwrite   = 1'b0;
        bus.iord       = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regdst     = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = AC_ADD;
        bus.readdata   = $urandom();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_ctrl();
    endtask

    task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_regs[r] = v;
    endtask

    // Reset while the control bundle is busy: every write must be discarded.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset          = 1'b1;
            bus.readdata   = 32'hFFFF_FFFF;
            bus.pcen       = 1'b1;
            bus.irwrite    = 1'b1;
            bus.regwrite   = 1'b1;
            bus.regdst     = 1'b0;
            bus.memtoreg   = 1'b1;
            bus.pcsrc      = 2'b01;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        idle_ctrl();
        bus.readdata = 32'hFFFF_FFFF;
        m_pc = 32'h0;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        expect_out("rst_adr", SEL_ADR, 32'h0);
        expect_out("rst_writedata", SEL_WD, 32'h0);
        expect_out("rst_op", SEL_OP, 32'h0);
        expect_out("rst_funct", SEL_FUNCT, 32'h0);
        tick();
    endtask

    function automatic logic [2:0] alu_code(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [31:0] r_result(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
        case (fn)
            6'h20:   return x + y;
            6'h22:   return x - y;
            6'h24:   return x & y;
            6'h25:   return x | y;
            default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Drives the standard multicycle control sequence for one instruction and
    // advances the instruction-level model.
    task automatic run_instr(input logic [31:0] ins);
        logic [5:0]  opc, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] simm, va, vb, res, addr;
        opc  = ins[31:26];
        fn   = ins[5:0];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        simm = {{16{ins[15]}}, ins[15:0]};
        va   = m_regs[rs];
        vb   = m_regs[rt];
        addr = va + simm;

        bus.irwrite    = 1'b1;
        bus.pcen       = 1'b1;
        bus.alusrcb    = 2'b01;
        bus.alucontrol = AC_ADD;
        bus.readdata   = ins;
        expect_out("fetch_adr", SEL_ADR, m_pc);
        tick();
        m_pc = m_pc + 32'd4;

        bus.alusrcb    = 2'b11;
        bus.alucontrol = AC_ADD;
        expect_out("decode_op", SEL_OP, {26'b0, opc});
        expect_out("decode_funct", SEL_FUNCT, {26'b0, fn});
        tick();

        case (opc)
            6'h08: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                expect_out("addi_zero", SEL_ZERO, {31'b0, (addr == 32'h0)});
                tick();
                bus.regwrite = 1'b1;
                tick();
                m_wr(rt, addr);
            end
            6'h00: begin
                res = r_result(fn, va, vb);
                bus.alusrca    = 1'b1;
                bus.alucontrol = alu_code(fn);
                expect_out("rtype_zero", SEL_ZERO, {31'b0, (res == 32'h0)});
                tick();
                bus.regwrite = 1'b1;
                bus.regdst   = 1'b1;
                tick();
                m_wr(rd, res);
            end
            6'h23, 6'h2b: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                tick();
                bus.iord = 1'b1;
                expect_out("mem_adr", SEL_ADR, addr);
                if (opc == 6'h2b) begin
                    expect_out("sw_writedata", SEL_WD, vb);
                    tick();
                    m_mem[addr] = vb;
                end else begin
                    if (!m_mem.exists(addr)) m_mem[addr] = $urandom();
                    bus.readdata = m_mem[addr];
                    tick();
                    bus.regwrite = 1'b1;
                    bus.memtoreg = 1'b1;
                    tick();
                    m_wr(rt, m_mem[addr]);
                end
            end
            6'h04: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = AC_SUB;
                bus.pcsrc      = 2'b01;
                bus.pcen       = (va == vb);
                expect_out("beq_zero", SEL_ZERO, {31'b0, (va == vb)});
                tick();
                if (va == vb) m_pc = m_pc + {simm[29:0], 2'b00};
            end
            default: begin
                bus.pcsrc = 2'b10;
                bus.pcen  = 1'b1;
                tick();
`ifdef DATAPATH_JUMP_EN
                m_pc = {m_pc[31:28], ins[25:0], 2'b00};
`else
                m_pc = m_pc + vb;
`endif
            end
        endcase
    endtask

    function automatic logic [31:0] i_type(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns [5];
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int          kind, off;
        fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        rs   = 5'($urandom_range(0, 15));
        rt   = 5'($urandom_range(0, 15));
        rd   = 5'($urandom_range(0, 15));
        imm  = 16'($urandom());
        kind = int'($urandom_range(0, 9));
        case (kind)
            0, 1, 2: return i_type(6'h08, rs, rt, imm);
            3, 4, 5: return {6'h00, rs, rt, rd, 5'h0, fns[$urandom_range(0, 4)]};
            6, 7: begin
                if ($urandom_range(0, 1) == 1) begin
                    rs  = 5'd0;
                    imm = 16'(4 * $urandom_range(0, 7));
                end
                return i_type((kind == 6) ? 6'h2b : 6'h23, rs, rt, imm);
            end
            8: begin
                off = int'($urandom_range(0, 16)) - 8;
                if ($urandom_range(0, 1) == 1) rt = rs;
                return i_type(6'h04, rs, rt, off[15:0]);
            end
            default: return {6'h02, 26'($urandom())};
        endcase
    endfunction

    initial begin
        idle_ctrl();
        do_reset(2);

        // Registers read as zero after reset.
        for (int k = 0; k < 4; k++) run_instr(i_type(6'h2b, 5'd0, 5'($urandom_range(1, 31)), 16'h0));

        run_instr(32'h2002_0005);                   // addi $2,$0,5
        run_instr(32'h2007_0003);                   // addi $7,$0,3
        run_instr(32'h00e2_2025);                   // or   $4,$7,$2
        run_instr(32'h2003_000c);                   // addi $3,$0,12
        run_instr(32'hac67_0044);                   // sw   $7,68($3)
        run_instr(32'h8c02_0050);                   // lw   $2,80($0)
        run_instr(i_type(6'h2b, 5'd0, 5'd2, 16'h0)); // sw $2,0($0)
        run_instr(i_type(6'h2b, 5'd0, 5'd4, 16'h4)); // sw $4,4($0)

        // Reset in the middle of an addi discards its pending writeback.
        bus.irwrite    = 1'b1;
        bus.pcen       = 1'b1;
        bus.alusrcb    = 2'b01;
        bus.readdata   = i_type(6'h08, 5'd0, 5'd9, 16'd77);
        tick();
        bus.alusrcb = 2'b11;
        tick();
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        tick();
        do_reset(1);
        run_instr(i_type(6'h2b, 5'd0, 5'd9, 16'h0));
        run_instr(i_type(6'h2b, 5'd0, 5'd2, 16'h0));
        run_instr(i_type(6'h2b, 5'd0, 5'd4, 16'h0));
        do_reset(1);

        run_instr(i_type(6'h08, 5'd0, 5'd5, 16'd21)); // addi $5,$0,21   @0
        run_instr(i_type(6'h04, 5'd5, 5'd5, 16'd2));  // beq $5,$5,2     @4 -> 16
        run_instr(i_type(6'h08, 5'd0, 5'd6, 16'd22)); // addi $6,$0,22   @16
        run_instr(i_type(6'h04, 5'd5, 5'd6, 16'd2));  // beq $5,$6,2 not taken
        run_instr(32'h0800_0010);                     // j 0x10
        run_instr(i_type(6'h08, 5'd0, 5'd0, 16'd9));  // addi $0,$0,9
        run_instr(i_type(6'h2b, 5'd0, 5'd0, 16'h0));  // sw $0 -> writedata 0
        run_instr(i_type(6'h2b, 5'd0, 5'd5, 16'h4));  // sw $5 -> 21

        for (int n = 0; n < 150; n++) run_instr(rand_instr());

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
